// File: rtl/vga_line_doubler.sv
// vga_line_doubler: 15 kHz -> 31 kHz scandoubler.
// Each input line is captured into one bank of a two-bank line buffer. The other
// bank, which holds the previous complete line, is replayed twice at the full
// F14M rate. The second replay can optionally be dimmed by half to give scanlines.
//
// Ports
//   F14M       system clock
//   RESET      asynchronous active-high reset
//   ce_pix     input pixel enable (F14M/2)
//   hs_in      input hsync, active low
//   vs_in      input vsync, active low
//   r_in/g_in/b_in  input colour, CW bits each
//   scanlines  1 = dim the second replay of each line by 50%
//   hs_out     output hsync, active low
//   vs_out     output vsync, active low
//   r_out/g_out/b_out  output colour, CW bits each
module vga_line_doubler #(
  parameter int unsigned MAX_LINE = 1024,
  parameter int unsigned AW       = 10,
  parameter int unsigned CW       = 6
) (
  input  logic          F14M,
  input  logic          RESET,
  input  logic          ce_pix,
  input  logic          hs_in,
  input  logic          vs_in,
  input  logic [CW-1:0] r_in,
  input  logic [CW-1:0] g_in,
  input  logic [CW-1:0] b_in,
  input  logic          scanlines,
  output logic          hs_out,
  output logic          vs_out,
  output logic [CW-1:0] r_out,
  output logic [CW-1:0] g_out,
  output logic [CW-1:0] b_out
);

  localparam int unsigned PW   = 3 * CW;
  localparam int unsigned CNTW = AW + 1;
  localparam logic [CNTW-1:0] MAX_CNT = CNTW'(MAX_LINE);

  // ---------------------------------------------------------------------------
  // Input side
  // ---------------------------------------------------------------------------
  logic            hs_prev;
  logic            hs_fall;
  logic            hs_rise;
  logic [CNTW-1:0] in_cnt;
  logic [CNTW-1:0] line_len;
  logic [CNTW-1:0] hs_cnt;
  logic [CNTW-1:0] hs_len;
  logic            wbank;

  assign hs_fall = ce_pix & hs_prev & ~hs_in;
  assign hs_rise = ce_pix & ~hs_prev & hs_in;

  always_ff @(posedge F14M or posedge RESET) begin
    if (RESET) begin
      hs_prev  <= 1'b1;
      in_cnt   <= '0;
      line_len <= '0;
      hs_cnt   <= '0;
      hs_len   <= '0;
      wbank    <= 1'b0;
    end else if (ce_pix) begin
      hs_prev <= hs_in;
      if (hs_fall) begin
        line_len <= in_cnt;
        wbank    <= ~wbank;
        // The pixel sampled with the falling edge is pixel 0 of the new line and
        // is written at address 0 below, so the next free address is 1.
        in_cnt   <= CNTW'(1);
      end else if (in_cnt < MAX_CNT) begin
        in_cnt <= in_cnt + 1'b1;
      end
      if (hs_fall) begin
        hs_cnt <= CNTW'(1);
      end else if (!hs_in && (hs_cnt < MAX_CNT)) begin
        hs_cnt <= hs_cnt + 1'b1;
      end
      if (hs_rise) begin
        hs_len <= hs_cnt;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Line buffer: two banks, bank index is the address MSB
  // ---------------------------------------------------------------------------
  logic          wr_en;
  logic          wr_bank;
  logic [AW-1:0] wr_addr;
  logic [PW-1:0] wr_data;
  logic [PW-1:0] rd_data;
  logic [PW-1:0] mem [2*MAX_LINE];

  logic [CNTW-1:0] out_cnt;

  always_comb begin
    wr_en   = ce_pix & (hs_fall | (in_cnt < MAX_CNT));
    wr_bank = hs_fall ? ~wbank : wbank;
    wr_addr = hs_fall ? '0 : in_cnt[AW-1:0];
    wr_data = {r_in, g_in, b_in};
  end

  // Read-first: a write into the read bank at the same address returns old data.
  always_ff @(posedge F14M) begin
    if (wr_en) begin
      mem[{wr_bank, wr_addr}] <= wr_data;
    end
    rd_data <= mem[{~wbank, out_cnt[AW-1:0]}];
  end

  // ---------------------------------------------------------------------------
  // Output side (every F14M cycle)
  // ---------------------------------------------------------------------------
  logic half;
  logic vs_hold;

  always_ff @(posedge F14M or posedge RESET) begin
    if (RESET) begin
      out_cnt <= '0;
      half    <= 1'b0;
      vs_hold <= 1'b1;
    end else begin
      // Resync wins over a wrap in the same cycle.
      if (hs_fall) begin
        out_cnt <= '0;
        half    <= 1'b0;
      end else if (line_len != '0) begin
        if (out_cnt >= line_len - 1'b1) begin
          out_cnt <= '0;
          half    <= ~half;
        end else begin
          out_cnt <= out_cnt + 1'b1;
        end
      end
      if (out_cnt == '0) begin
        vs_hold <= vs_in;
      end
    end
  end

  // Stage 0: timing decoded from out_cnt, aligned with the RAM address.
  logic blank0;
  logic hs0;
  logic vs0;
  logic dim0;

  always_comb begin
    blank0 = (line_len == '0);
    hs0    = ~(out_cnt < hs_len);
    // vsync only changes at an output line start.
    vs0    = (out_cnt == '0) ? vs_in : vs_hold;
    dim0   = scanlines & half;
  end

  // Stage 1: aligned with rd_data. Stage 2: output registers.
  logic blank1;
  logic hs1;
  logic vs1;
  logic dim1;
  logic [CW-1:0] rd_r;
  logic [CW-1:0] rd_g;
  logic [CW-1:0] rd_b;

  assign {rd_r, rd_g, rd_b} = rd_data;

  always_ff @(posedge F14M or posedge RESET) begin
    if (RESET) begin
      blank1 <= 1'b1;
      hs1    <= 1'b1;
      vs1    <= 1'b1;
      dim1   <= 1'b0;
      hs_out <= 1'b1;
      vs_out <= 1'b1;
      r_out  <= '0;
      g_out  <= '0;
      b_out  <= '0;
    end else begin
      blank1 <= blank0;
      hs1    <= hs0 | blank0;
      vs1    <= vs0 | blank0;
      dim1   <= dim0;
      hs_out <= hs1;
      vs_out <= vs1;
      if (blank1) begin
        r_out <= '0;
        g_out <= '0;
        b_out <= '0;
      end else if (dim1) begin
        r_out <= rd_r >> 1;
        g_out <= rd_g >> 1;
        b_out <= rd_b >> 1;
      end else begin
        r_out <= rd_r;
        g_out <= rd_g;
        b_out <= rd_b;
      end
    end
  end

endmodule
